// File: rtl/mode_counter.sv
// Up/down step counter that pulses on reaching all-ones/all-zeros and tallies those events into a game.
// Define GAMEOVER_HOLD_EN to freeze on game over until a load, instead of restarting on the next edge.
module mode_counter #(
  parameter int WIDTH     = 4,
  parameter int TALLY_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] init_value,
  output logic [WIDTH-1:0] count,
  output logic             winner,
  output logic             loser,
  output logic             winner_flag,
  output logic             loser_flag
);

  localparam logic [3:0] TMAX = 4'(TALLY_MAX);

  logic [WIDTH-1:0] count_q, count_d, step, nxt;
  logic             winner_q, winner_d, loser_q, loser_d;
  logic             winner_flag_q, winner_flag_d, loser_flag_q, loser_flag_d;
  logic [3:0]       win_tally_q, win_tally_d, lose_tally_q, lose_tally_d;
  logic             game_over;

  always_comb begin
    case (mode)
      2'b00:   step = WIDTH'(1);
      2'b01:   step = WIDTH'(2);
      2'b10:   step = '1;            // -1 in two's complement
      default: step = ~WIDTH'(1);    // -2
    endcase
  end

  assign nxt       = count_q + step;
  assign game_over = winner_flag_q | loser_flag_q;

  always_comb begin
    count_d       = count_q;
    winner_d      = 1'b0;
    loser_d       = 1'b0;
    win_tally_d   = win_tally_q;
    lose_tally_d  = lose_tally_q;
    winner_flag_d = winner_flag_q;
    loser_flag_d  = loser_flag_q;
    if (game_over) begin
`ifdef GAMEOVER_HOLD_EN
      if (load) begin
        count_d       = init_value;
        win_tally_d   = '0;
        lose_tally_d  = '0;
        winner_flag_d = 1'b0;
        loser_flag_d  = 1'b0;
      end
`else
      count_d       = '0;
      win_tally_d   = '0;
      lose_tally_d  = '0;
      winner_flag_d = 1'b0;
      loser_flag_d  = 1'b0;
`endif
    end else if (load) begin
      count_d = init_value;
    end else if (en) begin
      count_d  = nxt;
      winner_d = &nxt;
      loser_d  = ~|nxt;
      // the flag rises on the same edge as the pulse that completes the tally
      if (winner_d) begin
        win_tally_d = win_tally_q + 4'd1;
        if (win_tally_d == TMAX) winner_flag_d = 1'b1;
      end
      if (loser_d) begin
        lose_tally_d = lose_tally_q + 4'd1;
        if (lose_tally_d == TMAX) loser_flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= '0;
      winner_q      <= 1'b0;
      loser_q       <= 1'b0;
      win_tally_q   <= '0;
      lose_tally_q  <= '0;
      winner_flag_q <= 1'b0;
      loser_flag_q  <= 1'b0;
    end else begin
      count_q       <= count_d;
      winner_q      <= winner_d;
      loser_q       <= loser_d;
      win_tally_q   <= win_tally_d;
      lose_tally_q  <= lose_tally_d;
      winner_flag_q <= winner_flag_d;
      loser_flag_q  <= loser_flag_d;
    end
  end

  assign count       = count_q;
  assign winner      = winner_q;
  assign loser       = loser_q;
  assign winner_flag = winner_flag_q;
  assign loser_flag  = loser_flag_q;

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter (WIDTH=4, TALLY_MAX=15): driver queues expected outputs, monitor checks.
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [3:0] init_value = 4'h0;
  logic [3:0] count;
  logic       winner, loser, winner_flag, loser_flag;

  typedef struct {
    string      tag;
    logic [7:0] val;   // {count, winner, loser, winner_flag, loser_flag}
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  mode_counter #(.WIDTH(4), .TALLY_MAX(15)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .init_value(init_value),
    .count(count), .winner(winner), .loser(loser),
    .winner_flag(winner_flag), .loser_flag(loser_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {count, winner, loser, winner_flag, loser_flag};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got cnt=%h w=%b l=%b wf=%b lf=%b, want cnt=%h w=%b l=%b wf=%b lf=%b",
               name, act[7:4], act[3], act[2], act[1], act[0],
               exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // monitor: every edge with a queued expectation is checked just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.tag, outs(), e.val);
      end
    end
  end

  task automatic drive(input string tag, input logic e, input logic [1:0] m, input logic ld,
                       input logic [3:0] iv, input logic [3:0] ec,
                       input logic ew, input logic el, input logic ewf, input logic elf);
    @(negedge clk);
    en = e; mode = m; load = ld; init_value = iv;
    exp_q.push_back('{tag, {ec, ew, el, ewf, elf}});
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check({tag, "_imm"}, outs(), 8'h00);
    @(posedge clk);
    #1;
    check({tag, "_held"}, outs(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wins(input int n, input bit flag_last, input string tag);
    for (int i = 0; i < n; i++) begin
      drive({tag, "_ldE"}, 1'b0, 2'b00, 1'b1, 4'hE, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
      drive({tag, "_win"}, 1'b1, 2'b00, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0,
            flag_last && (i == n - 1), 1'b0);
    end
  endtask

  task automatic loses(input int n, input bit flag_last, input string tag);
    for (int i = 0; i < n; i++) begin
      drive({tag, "_ld1"}, 1'b0, 2'b00, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive({tag, "_lose"}, 1'b1, 2'b10, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1,
            1'b0, flag_last && (i == n - 1));
    end
  endtask

  // behaviour on the edges after a flag cycle; cnt is the count shown during the flag cycle
  task automatic after_flag(input bit is_win, input logic [3:0] cnt, input string tag);
`ifdef GAMEOVER_HOLD_EN
    for (int i = 0; i < 10; i++)
      drive({tag, "_frozen"}, 1'b1, 2'b00, 1'b0, 4'h0, cnt, 1'b0, 1'b0, is_win, !is_win);
    drive({tag, "_ld7"}, 1'b1, 2'b00, 1'b1, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    drive({tag, "_restart"}, 1'b1, 2'b00, 1'b1, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive({tag, "_post"}, 1'b1, 2'b00, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    #2;
    check("reset_imm", outs(), 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", outs(), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // idle after reset: no event from the reset value
    repeat (3) drive("idle", 1'b0, 2'b00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("first_inc", 1'b1, 2'b00, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);

    // +1 through all-ones and all-zeros
    drive("ldD", 1'b0, 2'b00, 1'b1, 4'hD, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("incE", 1'b1, 2'b00, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("incF", 1'b1, 2'b00, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("inc0", 1'b1, 2'b00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive("inc1", 1'b1, 2'b00, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);

    // -2 with wrap, loads of terminal values, hold, -1, +2 wrap, load priority
    drive("ld1", 1'b0, 2'b00, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("dec2F", 1'b1, 2'b11, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("dec2D", 1'b1, 2'b11, 1'b0, 4'h0, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("dec2B", 1'b1, 2'b11, 1'b0, 4'h0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("ldF", 1'b0, 2'b00, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("holdF", 1'b0, 2'b01, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("dec1E", 1'b1, 2'b10, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("inc2_0", 1'b1, 2'b01, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive("ld0", 1'b0, 2'b00, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("ldF2", 1'b0, 2'b00, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("inc2wrap", 1'b1, 2'b01, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("ld_over_en", 1'b1, 2'b00, 1'b1, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);

    // mid-game reset discards 14 wins; a full 15 are then needed
    async_reset("rst_a");
    wins(14, 1'b0, "g0");
    async_reset("rst_b");
    wins(15, 1'b1, "g1");
    after_flag(1'b1, 4'hF, "g1");

    // a fresh game after the flag also needs exactly 15 wins
    wins(15, 1'b1, "g2");
    after_flag(1'b1, 4'hF, "g2");

    // wins and losses tally independently
    wins(14, 1'b0, "g3w");
    loses(15, 1'b1, "g3l");
    after_flag(1'b0, 4'h0, "g3");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
